booth_mult_seq: RTL

- Iterative signed 32x32 radix-2 Booth multiplier sequencer; the controlling stage directly upstream of the single Booth step.
- Latches operands on a start pulse and builds the initial partial-product register. It then applies one Booth add/sub plus arithmetic-shift step per clock for WIDTH cycles.
- Returns the low word, an overflow flag and a one-cycle ready pulse to the multdiv/execute stage.

---
 rtl/booth_mult_if.sv | 20 ++
 rtl/booth_mult_seq.sv | 97 +++++++++
 2 files changed

// File: rtl/booth_mult_if.sv
// Operand/result bundle between the multdiv/execute stage and the Booth sequencer.
interface booth_mult_if #(parameter int WIDTH = 32);
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Iterative signed radix-2 Booth multiplier: one add/sub + arithmetic shift per clock.
// Optional BOOTH_ZERO_BYPASS_EN: a zero operand skips straight to DONE at load.
module booth_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic        clock,
  input  logic        reset,
  booth_mult_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     count;
  logic [2*WIDTH:0]     partial, partial_nxt;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     result_q;
  logic                 exc_q;
  logic [WIDTH:0]       hi_ext, mc_ext, sum;
  logic                 last_step;
  logic                 zero_op;
  logic [WIDTH:0]       prod_top;

`ifdef BOOTH_ZERO_BYPASS_EN
  assign zero_op = (bus.data_operandA == '0) || (bus.data_operandB == '0);
`else
  assign zero_op = 1'b0;
`endif

  assign last_step = (count == CNT_W'(WIDTH - 1));

  // High half kept one bit wider so subtracting mcand = -2^(WIDTH-1) cannot overflow.
  always_comb begin
    hi_ext = {partial[2*WIDTH], partial[2*WIDTH:WIDTH+1]};
    mc_ext = {mcand[WIDTH-1], mcand};
    unique case (partial[1:0])
      2'b01:   sum = hi_ext + mc_ext;
      2'b10:   sum = hi_ext + ~mc_ext + (WIDTH+1)'(1);
      default: sum = hi_ext;
    endcase
    partial_nxt = {sum, partial[WIDTH:1]};
    prod_top    = partial_nxt[2*WIDTH:WIDTH];
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy           = 1'b0;
    bus.data_resultRDY = 1'b0;
    unique case (state)
      IDLE: ;
      RUN: begin
        bus.busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        bus.data_resultRDY = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A load wins from any state; in RUN it discards the current op.
    if (bus.ctrl_MULT) state_nxt = zero_op ? DONE : RUN;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      partial  <= '0;
      mcand    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (bus.ctrl_MULT) begin
      mcand    <= bus.data_operandA;
      partial  <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
      count    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else if (state == RUN) begin
      partial <= partial_nxt;
      count   <= count + CNT_W'(1);
      if (last_step) begin
        result_q <= partial_nxt[WIDTH:1];
        exc_q    <= ~((&prod_top) | ~(|prod_top));
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;

endmodule
